shift_fifo_p: RTL and testbench
===============================

SHIFT_FIFO_P -- requirements
Module: shift_fifo_p

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64: data width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 16: number of entries (>=2).
REQ-003 The module SHALL have parameter CW, default 5: count width, equal to ceil(log2(DEPTH+1)).
REQ-004 The module SHALL have parameter AF_LVL, default 12: almost-full threshold, 1..DEPTH-1.
REQ-005 The module SHALL have parameter AE_LVL, default 2: almost-empty threshold, 1..DEPTH-1.
REQ-006 The module SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The module SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-009 The module SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-010 The module SHALL have port dataIn, input, WIDTH bits: write data.
REQ-011 The module SHALL have port push, input, 1 bit: write request.
REQ-012 The module SHALL have port pop, input, 1 bit: read request.
REQ-013 The module SHALL have port dataOut, output, WIDTH bits: oldest entry, combinational from state.
REQ-014 The module SHALL have port count, output, CW bits: current occupancy, 0..DEPTH.
REQ-015 The module SHALL have port full, output, 1 bit: count == DEPTH.
REQ-016 The module SHALL have port empty, output, 1 bit: count == 0.
REQ-017 The module SHALL have port almost_full, output, 1 bit: count >= AF_LVL.
REQ-018 The module SHALL have port almost_empty, output, 1 bit: count <= AE_LVL.
REQ-019 The module SHALL have port overflow, output, 1 bit: sticky; set when a push is dropped.
REQ-020 The module SHALL have port underflow, output, 1 bit: sticky; set when a pop is ignored.

Function
REQ-021 Storage SHALL be a DEPTH-entry shift register; an accepted push shifts all entries up one position and writes dataIn into entry 0.
REQ-022 dataOut SHALL equal entry[count-1] when count>0, and all-zeros when count==0.
REQ-023 A push is accepted iff push=1 and (count<DEPTH or pop=1).
REQ-024 A pop is accepted iff pop=1 and count>0.
REQ-025 Push-only accepted: count SHALL become count+1 on the next cycle.
REQ-026 Pop-only accepted: count SHALL become count-1; stored entries SHALL NOT move.
REQ-027 Push and pop both accepted (count>0, including count==DEPTH): the shift SHALL occur, count SHALL be unchanged, and the new dataOut SHALL be the next-oldest entry.
REQ-028 Push and pop with count==0: the push SHALL be accepted, the pop ignored, underflow SHALL be set, and count SHALL become 1.
REQ-029 Push with count==DEPTH and pop=0: the data SHALL be dropped, state SHALL be unchanged, and overflow SHALL be set.
REQ-030 Pop with count==0 and no push: state SHALL be unchanged and underflow SHALL be set.
REQ-031 Every flag SHALL be a pure function of registered count and SHALL update in the same cycle as count.
REQ-032 flush=1: count SHALL become 0 on the next edge; push and pop SHALL be ignored that cycle, with no flag updates from them; entry contents are don't-care.
REQ-033 clr_err=1: overflow and underflow SHALL be cleared on the next edge; a set condition in the same cycle SHALL win (flag=1).
REQ-034 Priority SHALL be rst > flush > push/pop; clr_err SHALL act independently of flush.
REQ-035 All arithmetic SHALL be CW bits wide, and count SHALL never leave the range 0..DEPTH.

Reset
REQ-036 rst=1 SHALL immediately, without waiting for a clock edge, force count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dataOut=0.
REQ-037 Storage entries need not be reset.
REQ-038 Reset asserted mid-operation SHALL discard all contents.
REQ-039 After rst deasserts, the first edge SHALL accept push and pop normally.

Verification (WIDTH=8, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-040 Push 0x11,0x22,0x33,0x44 -> count 1..4; full=1 after the 4th; almost_full=1 from count 3; dataOut=0x11 throughout.
REQ-041 Full, then push 0x55 with pop=0 -> count stays 4, overflow=1, then 4 pops yield 0x11,0x22,0x33,0x44 and empty=1.
REQ-042 Full {0x11..0x44}, then push 0x55 with pop=1 -> count stays 4, overflow=0, dataOut=0x22; draining yields 0x22,0x33,0x44,0x55.
REQ-043 Empty, then push 0xA5 with pop=1 -> count=1, dataOut=0xA5, underflow=1; clr_err -> underflow=0.
REQ-044 Count=3, then rst pulsed between edges -> count=0, dataOut=0 before the next edge; push 0x7E -> dataOut=0x7E.
REQ-045 Count=2, then flush with push=1 -> count=0, empty=1, no overflow or underflow set.

Source files
------------

// File: rtl/shift_fifo_p.sv
// ---------------------------------------------------------------------------
// shift_fifo_p
//
// A first-in first-out buffer built as a shift register. Each accepted write
// moves every entry up one slot and puts the new word in entry 0. The oldest
// word is therefore always at entry[count-1], so a read only decrements the
// occupancy and never moves data.
//
// Ports
//   clock        : single clock, all state changes on its rising edge
//   rst          : asynchronous active-high reset (clears occupancy and errors)
//   flush        : synchronous clear of contents; ignores push/pop that cycle
//   clr_err      : synchronous clear of the sticky overflow/underflow flags
//   dataIn       : write data
//   push         : write request
//   pop          : read request
//   dataOut      : oldest entry, or zero when empty (combinational from state)
//   count        : current occupancy, 0..DEPTH
//   full/empty   : count == DEPTH / count == 0
//   almost_full  : count >= AF_LVL
//   almost_empty : count <= AE_LVL
//   overflow     : sticky, set when a push is dropped
//   underflow    : sticky, set when a pop is ignored
// ---------------------------------------------------------------------------
module shift_fifo_p #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 16,
    parameter int CW     = 5,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] dataOut,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic is_full, is_empty;
    logic push_ok, pop_ok, shift_en;
    logic ovf_set, udf_set;

    assign is_full  = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);

    // A simultaneous pop frees the slot the push needs, so a push into a
    // full buffer is still accepted when pop is asserted.
    assign push_ok  = push & (~is_full | pop);
    assign pop_ok   = pop & ~is_empty;
    assign shift_en = push_ok & ~flush;

    // Error events are suppressed during flush.
    assign ovf_set  = ~flush & push & is_full & ~pop;
    assign udf_set  = ~flush & pop & is_empty;

    // Shifted image of the storage: new word enters at entry 0.
    always_comb begin
        mem_d[0] = dataIn;
        for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
        end
    end

    // Storage is not reset; the occupancy counter alone defines validity.
    always_ff @(posedge clock) begin
        if (shift_en) begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = count_q + ONE_C;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - ONE_C;
        end
    end

    // A set condition in the same cycle as clr_err wins.
    assign ovf_d = ovf_set | (ovf_q & ~clr_err);
    assign udf_d = udf_set | (udf_q & ~clr_err);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Oldest entry sits at count-1; a compare-select avoids indexing the
    // array with a count that is wider than the entry address.
    always_comb begin
        dataOut = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) begin
                dataOut = mem_q[i];
            end
        end
    end

    assign count        = count_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_shift_fifo_p.sv
// ---------------------------------------------------------------------------
// tb_shift_fifo_p
//
// Bench for shift_fifo_p with WIDTH=8, DEPTH=4, AF_LVL=3, AE_LVL=1.
// A queue-based reference model tracks the expected contents and sticky
// flags; one checker process compares every output on each falling edge
// (and on demand while rst is held between edges). Directed scenarios load
// literal expectations that the same checker also compares, followed by a
// randomized run.
// ---------------------------------------------------------------------------
module tb_shift_fifo_p;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [W-1:0]  dataIn = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [W-1:0]  dataOut;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    shift_fifo_p #(
        .WIDTH (W),
        .DEPTH (D),
        .CW    (CW),
        .AF_LVL(3),
        .AE_LVL(1)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .flush       (flush),
        .clr_err     (clr_err),
        .dataIn      (dataIn),
        .push        (push),
        .pop         (pop),
        .dataOut     (dataOut),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    // Reference model: front of the queue is the oldest word.
    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    // Literal expectations loaded by the stimulus process.
    bit           chk_en = 1'b0;
    bit           probe = 1'b0;
    bit           lit_en = 1'b0;
    int           lit_cnt;
    logic [W-1:0] lit_dout;
    bit           lit_full, lit_af, lit_ovf, lit_udf;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Single compare process.
    always @(negedge clock or posedge probe) begin
        if (chk_en) begin
            int sz;
            logic [W-1:0] edout;
            sz    = mq.size();
            edout = (sz > 0) ? mq[0] : '0;
            cmp("count", 32'(count), 32'(sz));
            cmp("dataOut", 32'(dataOut), 32'(edout));
            cmp("full", 32'(full), 32'(sz == D));
            cmp("empty", 32'(empty), 32'(sz == 0));
            cmp("almost_full", 32'(almost_full), 32'(sz >= 3));
            cmp("almost_empty", 32'(almost_empty), 32'(sz <= 1));
            cmp("overflow", 32'(overflow), 32'(m_ovf));
            cmp("underflow", 32'(underflow), 32'(m_udf));
            if (lit_en) begin
                cmp("lit_count", 32'(count), 32'(lit_cnt));
                cmp("lit_dataOut", 32'(dataOut), 32'(lit_dout));
                cmp("lit_full", 32'(full), 32'(lit_full));
                cmp("lit_almost_full", 32'(almost_full), 32'(lit_af));
                cmp("lit_overflow", 32'(overflow), 32'(lit_ovf));
                cmp("lit_underflow", 32'(underflow), 32'(lit_udf));
            end
        end
    end

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endfunction

    // Applies the rules for one clock edge using the inputs held over it.
    function automatic void model_edge();
        int sz;
        bit oset, uset;
        sz   = mq.size();
        oset = 1'b0;
        uset = 1'b0;
        if (flush) begin
            mq.delete();
        end else begin
            if (push && sz == D && !pop) oset = 1'b1;
            if (pop && sz == 0) uset = 1'b1;
            if (pop && sz > 0) void'(mq.pop_front());
            if (push && (sz < D || pop)) mq.push_back(dataIn);
        end
        m_ovf = oset | (m_ovf & !clr_err);
        m_udf = uset | (m_udf & !clr_err);
    endfunction

    task automatic step(input bit p, input bit q, input logic [W-1:0] d,
                        input bit f, input bit c);
        @(negedge clock);
        #1;
        lit_en  = 1'b0;
        push    = p;
        pop     = q;
        dataIn  = d;
        flush   = f;
        clr_err = c;
        @(posedge clock);
        #1;
        model_edge();
    endtask

    task automatic expect_lit(input int c, input logic [W-1:0] d, input bit fl,
                              input bit af, input bit o, input bit u);
        lit_cnt  = c;
        lit_dout = d;
        lit_full = fl;
        lit_af   = af;
        lit_ovf  = o;
        lit_udf  = u;
        lit_en   = 1'b1;
    endtask

    // Pulse rst between edges and check outputs before the next edge.
    task automatic pulse_rst(input bit with_lit);
        @(negedge clock);
        #1;
        lit_en  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        rst     = 1'b1;
        model_reset();
        if (with_lit) expect_lit(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        rst    = 1'b0;
        lit_en = 1'b0;
        @(posedge clock);
        #1;
        model_edge();
    endtask

    initial begin
        logic [W-1:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        model_reset();
        #1 chk_en = 1'b1;
        expect_lit(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        lit_en = 1'b0;
        @(negedge clock);
        #1 rst = 1'b0;

        // Fill: count 1..4, dataOut stays 0x11.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, vals[i], 0, 0);
            expect_lit(i + 1, 8'h11, i == 3, i >= 2, 1'b0, 1'b0);
        end
        // Push into full without pop: dropped, overflow set.
        step(1, 0, 8'h55, 0, 0);
        expect_lit(4, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'h00, 0, 0);
            expect_lit(3 - i, (i < 3) ? vals[i+1] : 8'h00, 1'b0, (3 - i) >= 3, 1'b1, 1'b0);
        end
        step(0, 0, 8'h00, 0, 1);
        expect_lit(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full then push+pop: shift-through.
        for (int i = 0; i < 4; i++) step(1, 0, vals[i], 0, 0);
        step(1, 1, 8'h55, 0, 0);
        expect_lit(4, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        step(0, 1, 8'h00, 0, 0);
        expect_lit(3, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        step(0, 1, 8'h00, 0, 0);
        expect_lit(2, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1, 8'h00, 0, 0);
        expect_lit(1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1, 8'h00, 0, 0);
        expect_lit(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Empty push+pop: push accepted, underflow set; clr_err clears it.
        step(1, 1, 8'hA5, 0, 0);
        expect_lit(1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        step(0, 0, 8'h00, 0, 1);
        expect_lit(1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Count 3, async reset between edges, then push.
        step(1, 0, 8'h01, 0, 0);
        step(1, 0, 8'h02, 0, 0);
        expect_lit(3, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_rst(1'b1);
        step(1, 0, 8'h7E, 0, 0);
        expect_lit(1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);

        // Count 2, flush with push: cleared, no error flags.
        step(1, 0, 8'h3C, 0, 0);
        step(1, 0, 8'h5A, 1, 0);
        expect_lit(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // Flush with pop on empty: no underflow.
        step(0, 1, 8'h00, 1, 0);
        expect_lit(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_rst(1'b0);
            end else begin
                step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                     8'($urandom), $urandom_range(0, 31) == 0,
                     $urandom_range(0, 15) == 0);
            end
        end
        step(0, 0, 8'h00, 0, 0);
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
